// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector with runtime-loadable pattern
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  // Active configuration
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;

  // Received-bit history (newest at [0]) and count of bits usable for a match
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;
  logic               cfg_ok;

  // Next history/fill for an accepted bit, and whether that bit completes the pattern
  always_comb begin
    hist_next = {hist_r[MAX_LEN-2:0], inp_bit};
    fill_next = (fill_r == LEN_W'(MAX_LEN)) ? fill_r : fill_r + LEN_W'(1);
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
    hit    = (fill_next >= len_r) && (((hist_next ^ pat_r) & len_mask) == '0);
    cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  // Config load, bit acceptance, match pulse and saturating counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r       <= MAX_LEN'(4'b1011);
      len_r       <= LEN_W'(4);
      ovl_r       <= 1'b1;
      hist_r      <= '0;
      fill_r      <= '0;
      seq_seen    <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      seq_seen <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_load) begin
        // A load always wins over a simultaneous data bit; that bit is dropped
        if (cfg_ok) begin
          pat_r       <= cfg_pattern;
          len_r       <= cfg_len;
          ovl_r       <= cfg_overlap;
          hist_r      <= '0;
          fill_r      <= '0;
          match_count <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (inp_valid) begin
        hist_r <= hist_next;
        if (hit) begin
          seq_seen <= 1'b1;
          // Non-overlapping mode restarts the fill so no matched bit is reused
          fill_r <= ovl_r ? fill_next : '0;
          if (match_count != {CNT_W{1'b1}}) begin
            match_count <= match_count + CNT_W'(1);
          end
        end else begin
          fill_r <= fill_next;
        end
      end
    end
  end

endmodule
